uart_tx_arbiter: RTL and testbench

Shares the single 32-bit UART transmitter among `NUM_REQ` independent requesters using round-robin arbitration. It sits between client blocks and the transmitter's `tx_data_valid` / `tx_byte` / `tx_done` handshake, and issues exactly one transmit launch per grant. It waits for frame completion before re-arbitrating. A watchdog releases the resource if `tx_done` never arrives.

---
 rtl/uart_ctrl_pkg.sv | 35 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 47 ++++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, frame
// timing constants and width helpers.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } arb_state_e;

  // One transmitted frame: 34 bit times at 86 clocks per bit.
  localparam int CLKS_PER_BIT = 86;
  localparam int FRAME_BITS   = 34;
  localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;

  // Smallest power of two that is >= n.
  function automatic int ceil_pow2(input int n);
    int p;
    p = 1;
    for (int i = 0; i < 31; i++) begin
      if (p < n) p = p * 2;
    end
    return p;
  endfunction

  // Watchdog limit: comfortably above one full frame (2924 -> 4096).
  localparam int DEFAULT_TIMEOUT_CYCLES = ceil_pow2(FRAME_CYCLES + 1);

  // Width of a grant index for n requesters (at least one bit).
  function automatic int grant_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first asserted request at or above the
// pointer, wrapping around to index 0.
module rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = grant_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(NUM_REQ);

  logic [IDX_W:0]   cand;
  logic             found;
  logic [IDX_W-1:0] sel;

  // Scan offsets 0..NUM_REQ-1 from the pointer; the first hit wins.
  always_comb begin
    cand  = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDX_W-1:0];
      end
    end
  end

  // Expand the selected index into a one-hot grant.
  always_comb begin
    gnt_o = '0;
    if (found) gnt_o[sel] = 1'b1;
  end

  assign idx_o = sel;
  assign any_o = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// One launch per grant; re-arbitration only after the frame completes (or
// the watchdog gives up) and the transmitter has dropped tx_done.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        iclk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [NUM_REQ-1:0]          req_done,
  output logic                        tx_data_valid,
  output logic [DATA_W-1:0]           tx_byte,
  input  logic                        tx_done,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IDX_W = grant_idx_w(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_id_q, grant_id_d;
  logic [DATA_W-1:0]   tx_byte_q, tx_byte_d;
  logic                tx_data_valid_q, tx_data_valid_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]  req_done_q, req_done_d;
  logic                timeout_err_q, timeout_err_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                tx_done_prev_q;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [DATA_W-1:0]   req_word [NUM_REQ];
  logic [NUM_REQ-1:0]  grant_oh;
  logic [IDX_W-1:0]    ptr_after_grant;
  logic [WD_W-1:0]     wd_inc;
  logic                done_edge;

  // Split the flat request bus into per-requester words.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign grant_oh        = NUM_REQ'(1) << grant_id_q;
  assign ptr_after_grant = (grant_id_q == IDX_LAST) ? '0 : grant_id_q + IDX_W'(1);
  // Saturating increment: the watchdog must never wrap back to zero.
  assign wd_inc          = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
  // Only a 0->1 transition counts, so a stuck-high tx_done is ignored.
  assign done_edge       = tx_done & ~tx_done_prev_q;

  // Next-state, datapath and pulse generation for the grant FSM.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    grant_id_d      = grant_id_q;
    tx_byte_d       = tx_byte_q;
    tx_data_valid_d = 1'b0;
    req_ack_d       = '0;
    req_done_d      = '0;
    timeout_err_d   = 1'b0;
    wd_d            = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_id_d      = pick_idx;
          tx_byte_d       = req_word[pick_idx];
          // Strobe and ack are registered so they are high during LAUNCH.
          tx_data_valid_d = 1'b1;
          req_ack_d       = pick_gnt;
          state_d         = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_d    = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        wd_d = wd_inc;
        if (done_edge) begin
          // A real completion wins over a simultaneous timeout.
          req_done_d = grant_oh;
          state_d    = ST_RELEASE;
        end else if (wd_inc == WD_LAST) begin
          // Fires as the count steps onto the limit, so the release pulse
          // lands TIMEOUT_CYCLES cycles after the launch strobe.
          req_done_d    = grant_oh;
          timeout_err_d = 1'b1;
          state_d       = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        ptr_d = ptr_after_grant;
        if (!tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      grant_id_q      <= '0;
      tx_byte_q       <= '0;
      tx_data_valid_q <= 1'b0;
      req_ack_q       <= '0;
      req_done_q      <= '0;
      timeout_err_q   <= 1'b0;
      wd_q            <= '0;
      tx_done_prev_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      grant_id_q      <= grant_id_d;
      tx_byte_q       <= tx_byte_d;
      tx_data_valid_q <= tx_data_valid_d;
      req_ack_q       <= req_ack_d;
      req_done_q      <= req_done_d;
      timeout_err_q   <= timeout_err_d;
      wd_q            <= wd_d;
      tx_done_prev_q  <= tx_done;
    end
  end

  assign req_ack       = req_ack_q;
  assign req_done      = req_done_q;
  assign tx_data_valid = tx_data_valid_q;
  assign tx_byte       = tx_byte_q;
  assign grant_id      = grant_id_q;
  assign timeout_err   = timeout_err_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a launch scoreboard, simple
// requester models and a scripted transmitter model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic            iclk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ack;
  logic [N-1:0]    req_done;
  logic            tx_data_valid;
  logic [DW-1:0]   tx_byte;
  logic            tx_done;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .iclk          (iclk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ack       (req_ack),
    .req_done      (req_done),
    .tx_data_valid (tx_data_valid),
    .tx_byte       (tx_byte),
    .tx_done       (tx_done),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc = 0, launches = 0, done_count = 0, tmo_count = 0;
  int last_launch_cyc = -100, tx_hi_cyc = -100, tx_rise_cyc = -100, tmo_cyc = 0;
  bit outstanding = 0;
  int cur_id = 0;
  logic [N-1:0] last_done = '0;
  bit last_tmo = 0;
  bit auto_tx = 0;
  int tx_delay = 3, done_len = 1, tx_wait = 0, tx_hold = 0;
  int cnt[N];
  int sent[N];

  function automatic logic [DW-1:0] word(input int i, input int n);
    return DW'(32'hA500_0000 | (i << 16) | n);
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [DW-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic start_req(input int i, input int count);
    cnt[i]  = count;
    sent[i] = 0;
    req_data[i*DW +: DW] = word(i, 0);
    req_valid[i] = 1'b1;
  endtask

  // One clock: sample outputs after the edge, score them, then drive the
  // requester and transmitter models for the next edge.
  task automatic step();
    exp_t e;
    bit   prev_done;
    @(posedge iclk);
    #1;
    cyc++;
    if (tx_data_valid) begin
      chk("single_outstanding", 64'(outstanding), 64'(0));
      chk("launch_gap_ge4", 64'((cyc - last_launch_cyc) >= 4), 64'(1));
      chk("launch_after_tx_idle", 64'((cyc - tx_hi_cyc) >= 3), 64'(1));
      if (exp_q.size() == 0) begin
        chk("unexpected_launch_qsize", 64'(exp_q.size()), 64'(1));
      end else begin
        e = exp_q.pop_front();
        chk("launch_grant_id", 64'(grant_id), 64'(e.id));
        chk("launch_tx_byte", 64'(tx_byte), 64'(e.data));
        chk("launch_req_ack", 64'(req_ack), 64'(oh(e.id)));
        cur_id = e.id;
      end
      $display("cycle %0d launch grant=%0d word=%h ack=%b", cyc, grant_id, tx_byte, req_ack);
      outstanding     = 1;
      last_launch_cyc = cyc;
      launches++;
    end else if (req_ack != '0) begin
      chk("stray_ack", 64'(req_ack), 64'(0));
    end
    if (req_done != '0) begin
      chk("done_outstanding", 64'(outstanding), 64'(1));
      chk("done_onehot", 64'(req_done), 64'(oh(cur_id)));
      if (!timeout_err) chk("done_latency", 64'(cyc - tx_rise_cyc), 64'(1));
      $display("cycle %0d done req_done=%b timeout=%0d", cyc, req_done, timeout_err);
      last_done   = req_done;
      last_tmo    = timeout_err;
      outstanding = 0;
      done_count++;
    end
    if (timeout_err) begin
      tmo_count++;
      tmo_cyc = cyc;
      chk("timeout_with_done", 64'(req_done != '0), 64'(1));
    end
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        sent[i]++;
        if (sent[i] < cnt[i]) req_data[i*DW +: DW] = word(i, sent[i]);
        else req_valid[i] = 1'b0;
      end
    end
    prev_done = tx_done;
    if (auto_tx && tx_data_valid) begin
      tx_wait = tx_delay;
    end else if (tx_wait > 0) begin
      tx_wait--;
      if (tx_wait == 0) tx_hold = done_len;
    end
    if (tx_hold > 0) begin
      tx_done = 1'b1;
      tx_hold--;
      tx_hi_cyc = cyc;
      if (!prev_done) tx_rise_cyc = cyc;
    end else begin
      tx_done = 1'b0;
    end
  endtask

  task automatic wait_launch(input string tag, input int budget);
    int l0 = launches;
    for (int n = 0; n < budget && launches == l0; n++) step();
    chk(tag, 64'(launches > l0), 64'(1));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_count;
    for (int n = 0; n < budget && done_count == d0; n++) step();
    chk(tag, 64'(done_count > d0), 64'(1));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    bit ok = 0;
    for (int n = 0; n < budget; n++) begin
      if (exp_q.size() == 0 && !outstanding && !busy && req_valid == '0) begin
        ok = 1;
        break;
      end
      step();
    end
    chk(tag, 64'(ok), 64'(1));
  endtask

  task automatic chk_idle_outputs(input string pfx);
    chk({pfx, "_busy"}, 64'(busy), 64'(0));
    chk({pfx, "_tx_data_valid"}, 64'(tx_data_valid), 64'(0));
    chk({pfx, "_req_ack"}, 64'(req_ack), 64'(0));
    chk({pfx, "_req_done"}, 64'(req_done), 64'(0));
    chk({pfx, "_timeout_err"}, 64'(timeout_err), 64'(0));
    chk({pfx, "_grant_id"}, 64'(grant_id), 64'(0));
    chk({pfx, "_tx_byte"}, 64'(tx_byte), 64'(0));
  endtask

  initial begin
    int l0, d0, t0, lc;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i]  = 0;
      sent[i] = 0;
    end
    repeat (3) step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Single request with a one-cycle tx_done pulse.
    auto_tx  = 1;
    done_len = 1;
    start_req(0, 1);
    req_data[0 +: DW] = 32'hDEADBEEF;
    push(0, 32'hDEADBEEF);
    step();
    chk("launch_latency", 64'(tx_data_valid), 64'(1));
    step();
    chk("valid_one_cycle", 64'(tx_data_valid), 64'(0));
    wait_done("single_done_seen", 40);
    chk("single_done_vec", 64'(last_done), 64'(4'b0001));
    step();
    chk("single_busy_clear", 64'(busy), 64'(0));

    // Pointer back to 0, then all four requesters contend.
    rst = 1'b1;
    step();
    rst = 1'b0;
    l0 = launches;
    d0 = done_count;
    start_req(0, 2);
    start_req(1, 1);
    start_req(2, 1);
    start_req(3, 1);
    push(0, word(0, 0));
    push(1, word(1, 0));
    push(2, word(2, 0));
    push(3, word(3, 0));
    push(0, word(0, 1));
    wait_drain("rr_drain", 400);
    chk("rr_launch_count", 64'(launches - l0), 64'(5));
    chk("rr_done_count", 64'(done_count - d0), 64'(5));

    // Requester 2 withdraws while requester 1 is in flight.
    l0 = launches;
    start_req(1, 1);
    start_req(2, 1);
    start_req(3, 1);
    push(1, word(1, 0));
    push(3, word(3, 0));
    wait_launch("drop_first_launch", 20);
    req_valid[2] = 1'b0;
    wait_drain("drop_drain", 200);
    chk("drop_launch_count", 64'(launches - l0), 64'(2));

    // Transmitter never answers: watchdog release.
    auto_tx = 0;
    t0 = tmo_count;
    start_req(0, 1);
    push(0, word(0, 0));
    wait_launch("tmo_launch", 20);
    lc = last_launch_cyc;
    for (int n = 0; n < 40 && tmo_count == t0; n++) step();
    chk("tmo_seen", 64'(tmo_count > t0), 64'(1));
    chk("tmo_latency", 64'(tmo_cyc - lc), 64'(TMO));
    chk("tmo_done_vec", 64'(last_done), 64'(4'b0001));
    wait_drain("tmo_drain", 20);
    chk("tmo_pulse_count", 64'(tmo_count - t0), 64'(1));
    auto_tx = 1;
    start_req(1, 1);
    push(1, word(1, 0));
    wait_done("post_tmo_done", 40);
    chk("post_tmo_no_err", 64'(last_tmo), 64'(0));
    chk("post_tmo_done_vec", 64'(last_done), 64'(4'b0010));
    wait_drain("post_tmo_drain", 20);

    // tx_done held high for two cycles.
    done_len = 2;
    l0 = launches;
    d0 = done_count;
    start_req(2, 2);
    push(2, word(2, 0));
    push(2, word(2, 1));
    wait_drain("hold_drain", 200);
    chk("hold_done_count", 64'(done_count - d0), 64'(2));
    chk("hold_launch_count", 64'(launches - l0), 64'(2));
    done_len = 1;

    // Reset while waiting for completion.
    auto_tx = 0;
    start_req(3, 1);
    push(3, word(3, 0));
    wait_launch("rst_launch", 20);
    repeat (3) step();
    chk("rst_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    step();
    chk_idle_outputs("midrst");
    rst = 1'b0;
    outstanding = 0;
    d0 = done_count;
    repeat (3) step();
    chk("midrst_no_done", 64'(done_count - d0), 64'(0));
    auto_tx = 1;
    start_req(3, 1);
    start_req(1, 1);
    push(1, word(1, 0));
    push(3, word(3, 0));
    wait_drain("midrst_drain", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
